// File: rtl/jt12_mix_uprate_n_if.sv
// rtl/jt12_mix_uprate_n_if.sv - sample/strobe bundle between sound sources, mixer and DAC side
interface jt12_mix_uprate_n_if #(
  parameter int NCH  = 4,
  parameter int INW  = 16,
  parameter int OUTW = 16
);
  logic                   cen_in;
  logic                   cen_out;
  logic [NCH*INW-1:0]     snd_in;
  logic [NCH*8-1:0]       gain;
  logic [NCH-1:0]         ch_en;
  logic signed [OUTW-1:0] snd;
  logic                   sat;
  logic                   overrun;

  modport master (
    output cen_in, cen_out, snd_in, gain, ch_en,
    input  snd, sat, overrun
  );

  modport slave (
    input  cen_in, cen_out, snd_in, gain, ch_en,
    output snd, sat, overrun
  );
endinterface

// File: rtl/jt12_mix_uprate_n.sv
// rtl/jt12_mix_uprate_n.sv - NCH-channel gain mixer (serial MAC), saturation and linear up-rater
module jt12_mix_uprate_n #(
  parameter int NCH       = 4,
  parameter int INW       = 16,
  parameter int OUTW      = 16,
  parameter int RATE_LOG2 = 2
) (
  input logic                clk,
  input logic                rst,
  jt12_mix_uprate_n_if.slave bus
);
  localparam int GW = $clog2(NCH);
  localparam int IW = (NCH > 1) ? GW : 1;
  localparam int PW = INW + 9;
  localparam int SW = PW + GW;
  localparam int MW = (SW > OUTW) ? SW : OUTW + 1;
  localparam int AW = OUTW + 1 + RATE_LOG2;
  localparam int KW = RATE_LOG2 + 1;

  localparam logic [KW-1:0]        K_END    = KW'(1 << RATE_LOG2);
  localparam logic [IW-1:0]        IDX_LAST = IW'(NCH - 1);
  localparam logic signed [MW-1:0] MIX_MAX  = $signed({{(MW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}});
  localparam logic signed [MW-1:0] MIX_MIN  = $signed({{(MW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}});

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_LOAD} state_t;

  state_t                 state;
  logic [NCH*INW-1:0]     snap_snd;
  logic [NCH*8-1:0]       snap_gain;
  logic [NCH-1:0]         snap_en;
  logic [IW-1:0]          idx;
  logic signed [SW-1:0]   sum;
  logic signed [OUTW-1:0] mix;
  logic signed [OUTW-1:0] prev;
  logic signed [OUTW-1:0] cur;
  logic signed [OUTW:0]   delta;
  logic signed [AW-1:0]   acc;
  logic [KW-1:0]          k;
  logic signed [OUTW-1:0] snd_r;
  logic                   sat_r;
  logic                   ovr_r;

  logic signed [INW-1:0]  ch_smp;
  logic [7:0]             ch_gain;
  logic                   ch_on;
  logic signed [PW-1:0]   prod;
  logic signed [MW-1:0]   mix_full;
  logic signed [AW-1:0]   acc_nx;
  logic signed [OUTW-1:0] ramp;

  // Gain is unsigned 4.4, so it enters the signed multiply with a forced zero sign bit.
  always_comb begin
    ch_smp   = snap_snd[int'(idx)*INW +: INW];
    ch_gain  = snap_gain[int'(idx)*8 +: 8];
    ch_on    = snap_en[int'(idx)];
    prod     = ch_on ? PW'(ch_smp) * PW'($signed({1'b0, ch_gain})) : '0;
    mix_full = MW'(sum >>> 4);
    acc_nx   = acc + AW'(delta);
    ramp     = OUTW'(AW'(prev) + (acc_nx >>> RATE_LOG2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      snap_snd  <= '0;
      snap_gain <= '0;
      snap_en   <= '0;
      idx       <= '0;
      sum       <= '0;
      mix       <= '0;
      prev      <= '0;
      cur       <= '0;
      delta     <= '0;
      acc       <= '0;
      k         <= '0;
      snd_r     <= '0;
      sat_r     <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      if (bus.cen_in && state != S_IDLE)
        ovr_r <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.cen_in) begin
            snap_snd  <= bus.snd_in;
            snap_gain <= bus.gain;
            snap_en   <= bus.ch_en;
            sum       <= '0;
            idx       <= '0;
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          sum <= sum + SW'(prod);
          idx <= idx + 1'b1;
          if (idx == IDX_LAST)
            state <= S_SAT;
        end
        S_SAT: begin
          if (mix_full > MIX_MAX) begin
            mix   <= OUTW'(MIX_MAX);
            sat_r <= 1'b1;
          end else if (mix_full < MIX_MIN) begin
            mix   <= OUTW'(MIX_MIN);
            sat_r <= 1'b1;
          end else begin
            mix <= OUTW'(mix_full);
          end
          state <= S_LOAD;
        end
        S_LOAD: begin
          // Ramp restarts from what is on the output now, so a late target never steps.
          prev  <= snd_r;
          cur   <= mix;
          delta <= (OUTW+1)'(mix) - (OUTW+1)'(snd_r);
          acc   <= '0;
          k     <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (bus.cen_out && state != S_LOAD) begin
        if (k < K_END) begin
          k     <= k + 1'b1;
          acc   <= acc_nx;
          snd_r <= ramp;
        end else begin
          snd_r <= cur;
        end
      end
    end
  end

  assign bus.snd     = snd_r;
  assign bus.sat     = sat_r;
  assign bus.overrun = ovr_r;
endmodule

// File: tb/tb_jt12_mix_uprate_n.sv
// tb/tb_jt12_mix_uprate_n.sv - two up-rate ratios (4 and 1) driven in parallel against a reference model
module tb_jt12_mix_uprate_n;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt12_mix_uprate_n_if #(.NCH(NCH), .INW(16), .OUTW(16)) bus0 ();
  jt12_mix_uprate_n_if #(.NCH(NCH), .INW(16), .OUTW(16)) bus1 ();

  assign bus1.cen_in  = bus0.cen_in;
  assign bus1.cen_out = bus0.cen_out;
  assign bus1.snd_in  = bus0.snd_in;
  assign bus1.gain    = bus0.gain;
  assign bus1.ch_en   = bus0.ch_en;

  jt12_mix_uprate_n #(.NCH(NCH), .INW(16), .OUTW(16), .RATE_LOG2(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  jt12_mix_uprate_n #(.NCH(NCH), .INW(16), .OUTW(16), .RATE_LOG2(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void mix_of(input logic [63:0] s, input logic [31:0] g, input logic [3:0] e,
                                 output int mix, output bit clp);
    int sum;
    sum = 0;
    for (int c = 0; c < NCH; c++)
      if (e[c]) sum += int'($signed(s[c*16 +: 16])) * int'(g[c*8 +: 8]);
    mix = sum >>> 4;
    clp = 1'b0;
    if (mix > 32767) begin
      mix = 32767; clp = 1'b1;
    end else if (mix < -32768) begin
      mix = -32768; clp = 1'b1;
    end
  endfunction

  function automatic int rl(input int j);
    return (j == 0) ? 2 : 0;
  endfunction

  // Reference: a mix accepted at edge t becomes the target at edge t+NCH+2; output ramps linearly.
  int cyc = 0;
  bit armed = 1'b0;
  bit pend = 1'b0;
  int load_cyc, pend_mix;
  bit pend_sat, is_load;
  bit m_sat, m_ovr;
  int m_snd[2], m_prev[2], m_cur[2], m_k[2];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed = 1'b1;
      pend  = 1'b0;
      m_sat = 1'b0;
      m_ovr = 1'b0;
      for (int j = 0; j < 2; j++) begin
        m_snd[j] = 0; m_prev[j] = 0; m_cur[j] = 0; m_k[j] = 0;
      end
    end else begin
      is_load = pend && (cyc == load_cyc);
      for (int j = 0; j < 2; j++) begin
        if (bus0.cen_out && !is_load) begin
          if (m_k[j] < (1 << rl(j))) begin
            m_k[j]++;
            m_snd[j] = m_prev[j] + (((m_cur[j] - m_prev[j]) * m_k[j]) >>> rl(j));
          end else begin
            m_snd[j] = m_cur[j];
          end
        end
        if (is_load) begin
          m_prev[j] = m_snd[j];
          m_cur[j]  = pend_mix;
          m_k[j]    = 0;
        end
      end
      if (pend && cyc == load_cyc - 1 && pend_sat) m_sat = 1'b1;
      if (bus0.cen_in) begin
        if (pend) m_ovr = 1'b1;
        else begin
          mix_of(bus0.snd_in, bus0.gain, bus0.ch_en, pend_mix, pend_sat);
          pend = 1'b1;
          load_cyc = cyc + NCH + 2;
        end
      end
      if (is_load) pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("snd_r4", bus0.snd, m_snd[0]);
      chk("snd_r1", bus1.snd, m_snd[1]);
      chk("sat_r4", 32'(bus0.sat), 32'(m_sat));
      chk("sat_r1", 32'(bus1.sat), 32'(m_sat));
      chk("ovr_r4", 32'(bus0.overrun), 32'(m_ovr));
      chk("ovr_r1", 32'(bus1.overrun), 32'(m_ovr));
    end
  end

  task automatic step(input bit ci, input bit co);
    bus0.cen_in  = ci;
    bus0.cen_out = co;
    @(negedge clk);
    bus0.cen_in  = 1'b0;
    bus0.cen_out = 1'b0;
  endtask

  task automatic scramble();
    bus0.snd_in = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1)
      for (int c = 0; c < NCH; c++) bus0.snd_in[c*16 +: 16] = 16'($signed($urandom_range(0, 4000)) - 2000);
    bus0.gain  = $urandom;
    bus0.ch_en = 4'($urandom);
  endtask

  task automatic set_in(input logic [63:0] s, input logic [31:0] g, input logic [3:0] e);
    bus0.snd_in = s;
    bus0.gain   = g;
    bus0.ch_en  = e;
  endtask

  // cen_in, then scrambled inputs while the snapshot is being mixed, up to and including LOAD.
  task automatic mix_now();
    step(1'b1, 1'b0);
    for (int i = 0; i < NCH + 2; i++) begin
      scramble();
      step(1'b0, 1'b0);
    end
  endtask

  task automatic ramp4();
    repeat (4) step(1'b0, 1'b1);
  endtask

  int pm;
  bit pc;

  initial begin
    bus0.cen_in = 1'b0;
    bus0.cen_out = 1'b0;
    scramble();

    mix_of({48'd0, 16'd1000}, 32'h0000_0010, 4'b0001, pm, pc);
    chk("model_unity", pm, 1000);
    mix_of({32'd0, 16'h7000, 16'h7000}, 32'h0000_1010, 4'b0011, pm, pc);
    chk("model_pos_clamp", pm, 32767);
    chk("model_pos_clamp_flag", 32'(pc), 1);
    mix_of({32'd0, 16'h9000, 16'h9000}, 32'h0000_1010, 4'b0011, pm, pc);
    chk("model_neg_clamp", pm, -32768);
    mix_of({48'd0, 16'hFED4}, 32'h0000_0008, 4'b0001, pm, pc);
    chk("model_half_gain", pm, -150);

    rst = 1'b1;
    repeat (3) begin
      scramble();
      step(1'b0, 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    chk("rst_snd", bus0.snd, 0);
    chk("rst_sat", 32'(bus0.sat), 0);
    chk("rst_ovr", 32'(bus0.overrun), 0);
    repeat (8) begin
      scramble();
      step(1'b0, 1'($urandom_range(0, 1)));
    end
    chk("idle_snd", bus0.snd, 0);

    set_in({48'd0, 16'd1000}, 32'h0000_0010, 4'b0001);
    mix_now();
    step(1'b0, 1'b1);
    chk("zoh_first", bus1.snd, 1000);
    chk("ramp_first", bus0.snd, 250);
    repeat (3) step(1'b0, 1'b1);
    chk("ramp_end_1000", bus0.snd, 1000);

    set_in({32'd0, 16'h7000, 16'h7000}, 32'h0000_1010, 4'b0011);
    mix_now();
    chk("sat_pos_flag", 32'(bus0.sat), 1);
    ramp4();
    chk("sat_pos_snd", bus0.snd, 32767);
    set_in({32'd0, 16'h9000, 16'h9000}, 32'h0000_1010, 4'b0011);
    mix_now();
    ramp4();
    chk("sat_neg_snd", bus0.snd, -32768);

    set_in({48'd0, 16'hFED4}, 32'h0000_0008, 4'b0001);
    mix_now();
    ramp4();
    chk("half_gain", bus0.snd, -150);
    set_in({48'd0, 16'hFED4}, 32'h0000_0000, 4'b0001);
    mix_now();
    ramp4();
    chk("zero_gain", bus0.snd, 0);

    set_in({48'd0, 16'd400}, 32'h0000_0010, 4'b0001);
    mix_now();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1);
      chk("ramp_400", bus0.snd, (i < 4) ? 100 * i : 400);
    end

    chk("ovr_before", 32'(bus0.overrun), 0);
    set_in({48'd0, 16'hFCE0}, 32'h0000_0010, 4'b0001);
    step(1'b1, 1'b0);
    set_in({48'd0, 16'd2000}, 32'h0000_0010, 4'b0001);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("overrun_set", 32'(bus0.overrun), 1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("load_skip_r4", bus0.snd, 400);
    chk("load_skip_r1", bus1.snd, 400);
    ramp4();
    chk("first_mix_kept", bus0.snd, -800);

    set_in({48'd0, 16'd5000}, 32'h0000_0010, 4'b0001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    repeat (10) step(1'b0, 1'b1);
    chk("abort_snd", bus0.snd, 0);
    chk("abort_ovr", 32'(bus0.overrun), 0);

    repeat (3000) begin
      scramble();
      rst = ($urandom_range(0, 599) == 0);
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;
    repeat (20) step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
